// File: rtl/std_io_shift_pkg.sv
// Shared types and helpers for the bit-serial bidirectional shifter.
package std_io_shift_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_TURN,
        ST_RX,
        ST_DONE
    } std_io_shift_state_t;

    // Limit a requested bit count to the width of the data word.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/std_io_bit_timer.sv
// Bit timer: phase counter 0..CLKS_PER_BIT-1 plus a bit counter that advances
// on each phase wrap. A restart pulse zeroes both counters.
module std_io_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PH_W         = 3,
    parameter int BIT_W        = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             restart,
    output logic [PH_W-1:0]  phase,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             wrap,
    output logic             mid
);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;

    assign wrap    = (phase_q == PH_W'(CLKS_PER_BIT - 1));
    assign mid     = (phase_q == PH_W'(CLKS_PER_BIT / 2));
    assign phase   = phase_q;
    assign bit_cnt = bit_q;

    // Next phase/bit values: restart wins, otherwise count and wrap.
    always_comb begin
        phase_d = phase_q + PH_W'(1);
        bit_d   = bit_q;
        if (restart) begin
            phase_d = '0;
            bit_d   = '0;
        end else if (wrap) begin
            phase_d = '0;
            bit_d   = bit_q + BIT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/std_io_bidir_shifter.sv
// Half-duplex single-wire transceiver: send a word MSB-first, release the
// bus for a turnaround, then receive a word. Drives a registered tri-state
// pad cell (ena/drv/data) and samples the pad readback.
// Optional macro STD_IO_BIDIR_SHIFTER_SYNC_EN adds a 2-flop synchronizer on io_in.
module std_io_bidir_shifter
    import std_io_shift_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int LEN_W        = $clog2(DATA_W + 1),
    parameter int CLKS_PER_BIT = 8,
    parameter int TURN_BITS    = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic [LEN_W-1:0]  tx_len,
    input  logic [DATA_W-1:0] tx_word,
    input  logic [LEN_W-1:0]  rx_len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_word,
    output logic              io_ena,
    output logic              io_drv,
    output logic              io_data,
    input  logic              io_in
);

    localparam int PH_W  = $clog2(CLKS_PER_BIT);
    localparam int TB_W  = $clog2(TURN_BITS + 1);
    localparam int BIT_W = (TB_W > LEN_W) ? TB_W : LEN_W;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be >= 4 and even");
        end
        if (TURN_BITS < 1) begin : g_bad_turn
            $error("TURN_BITS must be >= 1");
        end
    endgenerate

    std_io_shift_state_t state_q, state_d;
    logic [LEN_W-1:0]    tx_len_q, tx_len_d, rx_len_q, rx_len_d;
    logic [LEN_W-1:0]    tx_len_c, rx_len_c;
    logic [DATA_W-1:0]   tx_word_q, tx_word_d, rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_word_q, rx_word_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                io_ena_q, io_ena_d, io_drv_q, io_drv_d, io_data_q, io_data_d;
    logic                restart, wrap, mid, io_s;
    logic [PH_W-1:0]     phase;
    logic [BIT_W-1:0]    bit_cnt;
    int                  tx_idx;

`ifdef STD_IO_BIDIR_SHIFTER_SYNC_EN
    generate
        if (CLKS_PER_BIT < 6) begin : g_bad_sync_cpb
            $error("CLKS_PER_BIT must be >= 6 with the input synchronizer");
        end
    endgenerate

    logic sync1_q, sync1_d, sync2_q, sync2_d;

    // Two-stage synchronizer path for the asynchronous pad readback.
    always_comb begin
        sync1_d = io_in;
        sync2_d = sync1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign io_s = sync2_q;
`else
    assign io_s = io_in;
`endif

    assign tx_len_c = LEN_W'(clamp_len(int'(tx_len), DATA_W));
    assign rx_len_c = LEN_W'(clamp_len(int'(rx_len), DATA_W));
    assign restart  = (state_d != state_q);

    std_io_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PH_W        (PH_W),
        .BIT_W       (BIT_W)
    ) u_timer (
        .clk    (clk),
        .clrn   (clrn),
        .restart(restart),
        .phase  (phase),
        .bit_cnt(bit_cnt),
        .wrap   (wrap),
        .mid    (mid)
    );

    // Transaction sequencing, request latching and receive shifting.
    always_comb begin
        state_d    = state_q;
        tx_len_d   = tx_len_q;
        rx_len_d   = rx_len_q;
        tx_word_d  = tx_word_q;
        rx_shift_d = rx_shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_len_d   = tx_len_c;
                    rx_len_d   = rx_len_c;
                    tx_word_d  = tx_word;
                    rx_shift_d = '0;
                    state_d    = (tx_len_c != '0) ? ST_TX : ST_TURN;
                end
            end
            ST_TX: begin
                if (wrap && int'(bit_cnt) == int'(tx_len_q) - 1) state_d = ST_TURN;
            end
            ST_TURN: begin
                if (wrap && int'(bit_cnt) == TURN_BITS - 1)
                    state_d = (rx_len_q != '0) ? ST_RX : ST_DONE;
            end
            ST_RX: begin
                if (mid) rx_shift_d = {rx_shift_q[DATA_W-2:0], io_s};
                if (wrap && int'(bit_cnt) == int'(rx_len_q) - 1) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the state/phase of the next cycle,
    // so a drive pulse lands exactly on phase 0 of each bit.
    always_comb begin
        io_ena_d  = 1'b0;
        io_drv_d  = 1'b0;
        io_data_d = 1'b0;
        rx_word_d = rx_word_q;
        busy_d    = (state_d == ST_TX) || (state_d == ST_TURN) || (state_d == ST_RX);
        done_d    = (state_d == ST_DONE);
        tx_idx    = int'(tx_len_d) - 1 - (restart ? 0 : int'(bit_cnt) + 1);
        if (state_d == ST_TX && (restart || wrap)) begin
            io_ena_d  = 1'b1;
            io_drv_d  = 1'b1;
            io_data_d = tx_word_d[IDX_W'(tx_idx)];
        end
        if (state_d == ST_TURN && restart) io_ena_d = 1'b1;
        if (state_d == ST_DONE) rx_word_d = (rx_len_q == '0) ? '0 : rx_shift_q;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            tx_len_q  <= '0;
            rx_len_q  <= '0;
            rx_word_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            io_ena_q  <= 1'b0;
            io_drv_q  <= 1'b0;
            io_data_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_len_q  <= tx_len_d;
            rx_len_q  <= rx_len_d;
            rx_word_q <= rx_word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            io_ena_q  <= io_ena_d;
            io_drv_q  <= io_drv_d;
            io_data_q <= io_data_d;
        end
    end

    // Data registers; cleared on accept, so no reset needed.
    always_ff @(posedge clk) begin
        tx_word_q  <= tx_word_d;
        rx_shift_q <= rx_shift_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_word = rx_word_q;
    assign io_ena  = io_ena_q;
    assign io_drv  = io_drv_q;
    assign io_data = io_data_q;

endmodule

// File: tb/tb_std_io_bidir_shifter.sv
// Testbench for std_io_bidir_shifter: per-cycle reference model of the pad
// drive schedule, busy/done timing and received word.
module tb_std_io_bidir_shifter;

    localparam int DW = 16;
    localparam int LW = 5;
    localparam int TB = 1;
`ifdef STD_IO_BIDIR_SHIFTER_SYNC_EN
    localparam int CPB = 8;
`else
    localparam int CPB = 4;
`endif

    logic          clk = 1'b0;
    logic          clrn, start, io_in;
    logic [LW-1:0] tx_len, rx_len;
    logic [DW-1:0] tx_word;
    logic          busy, done, io_ena, io_drv, io_data;
    logic [DW-1:0] rx_word;

    int n_tests = 0;
    int n_fail  = 0;

    std_io_bidir_shifter #(
        .DATA_W(DW), .LEN_W(LW), .CLKS_PER_BIT(CPB), .TURN_BITS(TB)
    ) dut (
        .clk(clk), .clrn(clrn), .start(start), .tx_len(tx_len), .tx_word(tx_word),
        .rx_len(rx_len), .busy(busy), .done(done), .rx_word(rx_word),
        .io_ena(io_ena), .io_drv(io_drv), .io_data(io_data), .io_in(io_in)
    );

    always #5 clk = ~clk;

    // Run one transaction; start is high in cycle T, outputs of cycle T+c are
    // sampled on the falling edge inside that cycle.
    task automatic run_txn(input int tl, input int tw, input int rl, input int rv,
                           input int extra_c, input int abort_c, input string name);
        int ltx, lrx, last, rx0, t, slot, j, e_rx;
        logic e_busy, e_done, e_ena, e_data;
        ltx  = (tl > DW) ? DW : tl;
        lrx  = (rl > DW) ? DW : rl;
        last = 1 + (ltx + TB + lrx) * CPB;
        rx0  = 1 + (ltx + TB) * CPB;
        e_rx = (lrx == 0) ? 0 : (rv & ((1 << lrx) - 1));
        @(negedge clk);
        start = 1'b1; tx_len = LW'(tl); tx_word = DW'(tw); rx_len = LW'(rl);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; tx_len = LW'($urandom); rx_len = LW'($urandom); tx_word = DW'($urandom);
            end
            if (c == abort_c) begin
                clrn = 1'b0;
                #1;
                n_tests++;
                if ({busy, done, io_ena, io_drv, io_data, rx_word} !== '0)
                    $display("FAIL %s abort_outputs got %b%b%b%b%b %h want all 0", name,
                             busy, done, io_ena, io_drv, io_data, rx_word);
                if ({busy, done, io_ena, io_drv, io_data, rx_word} !== '0) n_fail++;
                return;
            end
            t = c - 1; slot = t / CPB;
            e_busy = (c < last); e_done = (c == last); e_ena = 1'b0; e_data = 1'b0;
            if (slot < ltx) begin
                if (t % CPB == 0) begin
                    e_ena  = 1'b1;
                    e_data = 1'((tw >> (ltx - 1 - slot)) & 1);
                end
            end else if (t == ltx * CPB) begin
                e_ena = 1'b1;
            end
            n_tests++;
            if (busy !== e_busy) begin
                n_fail++; $display("FAIL %s busy c=%0d got %b want %b", name, c, busy, e_busy);
            end
            n_tests++;
            if (done !== e_done) begin
                n_fail++; $display("FAIL %s done c=%0d got %b want %b", name, c, done, e_done);
            end
            n_tests++;
            if (io_ena !== e_ena) begin
                n_fail++; $display("FAIL %s io_ena c=%0d got %b want %b", name, c, io_ena, e_ena);
            end
            if (e_ena) begin
                n_tests++;
                if (io_drv !== (slot < ltx)) begin
                    n_fail++; $display("FAIL %s io_drv c=%0d got %b want %b", name, c, io_drv, slot < ltx);
                end
                n_tests++;
                if (io_data !== e_data) begin
                    n_fail++; $display("FAIL %s io_data c=%0d got %b want %b", name, c, io_data, e_data);
                end
            end
            if (c == last) begin
                n_tests++;
                if (rx_word !== DW'(e_rx)) begin
                    n_fail++; $display("FAIL %s rx_word got %h want %h", name, rx_word, DW'(e_rx));
                end
            end
            if (c >= rx0 && c < rx0 + lrx * CPB) begin
                j = (c - rx0) / CPB;
                io_in = 1'((rv >> (lrx - 1 - j)) & 1);
            end else begin
                io_in = 1'($urandom);
            end
            if (c == extra_c) begin
                start = 1'b1; tx_len = LW'($urandom); rx_len = LW'($urandom);
            end
            if (c == extra_c + 1) start = 1'b0;
            if (c == last) begin
                start = 1'b1; tx_len = LW'(2); rx_len = LW'(1);
            end
        end
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || io_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle_after_done k=%0d busy=%b done=%b ena=%b want 0", name, k, busy, done, io_ena);
            end
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; start = 1'b0; tx_len = '0; rx_len = '0; tx_word = '0; io_in = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, done, io_ena, io_drv, io_data} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, io_ena, io_drv, io_data});
        end
        n_tests++;
        if (rx_word !== '0) begin
            n_fail++; $display("FAIL reset_rx_word got %h want 0", rx_word);
        end
        clrn = 1'b1;
    endtask

    task automatic test_directed();
        run_txn(8, 'h00A5, 0, 0, 0, 0, "tx_only_a5");
        run_txn(4, 'h0009, 8, 'h3C, 0, 0, "tx_rx_3c");
        run_txn(0, 'h0000, 0, 0, 0, 0, "zero_len");
        run_txn(20, 'hFFFF, 0, 0, 10, 0, "clamp_busy_start");
    endtask

    task automatic test_abort();
        run_txn(4, 'h0009, 8, 'h3C, 0, 30, "abort");
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0 || io_ena !== 1'b0) begin
                n_fail++; $display("FAIL abort_hold done=%b busy=%b ena=%b want 0", done, busy, io_ena);
            end
        end
        clrn = 1'b1;
        run_txn(4, 'h0009, 8, 'h3C, 0, 0, "after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(2, 40)), 0, "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/std_io_bidir_shifter.md
Name: std_io_bidir_shifter

Overview:
- Half-duplex, single-wire, bit-serial transceiver.
- Sits directly upstream of the registered tri-state pad cell: it generates the cell's ena/drv/data and samples the pad value back.
- A transaction has three phases: transmit a word MSB-first, release the bus for a turnaround, then receive a word.
- Used for 1-wire-style sensor and config links.

Parameters:
- DATA_W, 16, maximum bits per direction.
- LEN_W, $clog2(DATA_W+1), width of the length fields.
- CLKS_PER_BIT, 8, clk cycles per bit time; must be >=4 and even (elaboration assertion).
- TURN_BITS, 1, bit times with the bus released between TX and RX; must be >=1.

Ports:
- clk  in  1  clock
- clrn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- tx_len  in  LEN_W  number of bits to send; values >DATA_W clamp to DATA_W
- tx_word  in  DATA_W  bits tx_word[tx_len-1:0] are sent MSB-first
- rx_len  in  LEN_W  number of bits to receive; clamped like tx_len
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rx_word  out  DATA_W  received bits, right-aligned, zero-extended
- io_ena  out  1  to pad-cell ena
- io_drv  out  1  to pad-cell drv
- io_data  out  1  to pad-cell data
- io_in  in  1  pad readback

Behaviour:
- Reset: clrn is asynchronous, active-low; clock is clk. Asserting clrn forces, immediately: state=IDLE, busy=0, done=0, rx_word=0, io_ena=0, io_drv=0, io_data=0, all counters=0.
- All outputs are registered.
- States: IDLE, TX, TURN, RX, DONE.
- Bit timer: phase counter runs 0..CLKS_PER_BIT-1, reloads to 0 on every state entry, and wraps per bit. The bit counter increments on each wrap.
- IDLE:
  - busy=0; io_ena=0.
  - On start, latch the clamped lengths and tx_word, then go to TX if tx_len>0, else TURN.
- Accept timing: start is accepted in cycle T. First TX/TURN cycle is T+1. busy=1 from T+1.
- TX:
  - At phase 0 of bit k: io_ena=1, io_drv=1, io_data=tx_word[tx_len-1-k].
  - io_ena=0 at every other phase.
  - After tx_len bits, go to TURN.
- TURN:
  - At entry (phase 0): io_ena=1, io_drv=0 (pad released).
  - Hold for TURN_BITS bit times.
  - Then go to RX if rx_len>0, else DONE.
  - TURN always executes, so every transaction ends with the bus released.
- RX:
  - Sample io_in at phase CLKS_PER_BIT/2; shift left into rx_shift (first bit received ends up MSB of the received field).
  - No pad drive in this state.
  - After rx_len bits, go to DONE.
- DONE (one cycle):
  - rx_word<=rx_shift; done=1; busy=0; return to IDLE.
  - If rx_len=0, rx_word<=0.
- Timing:
  - done asserts at T+1+(tx_len+TURN_BITS+rx_len)*CLKS_PER_BIT.
  - The pad lags io_* by 1 cycle (pad-cell register).
- Boundaries:
  - start while busy=1 is ignored (no queueing).
  - start in the DONE cycle is ignored.
  - Input changes mid-transaction have no effect (latched at accept).
  - clrn mid-transaction aborts with no done pulse; the pad cell shares clrn and also goes to Z.
  - The next start after reset behaves normally.

Optional Feature:
- Macro: STD_IO_BIDIR_SHIFTER_SYNC_EN.
- Defined:
  - io_in passes through a 2-flop synchronizer before sampling.
  - Sample point is unchanged (phase CLKS_PER_BIT/2); the sampled value reflects the pad 2 cycles earlier.
  - Elaboration asserts CLKS_PER_BIT>=6.
- Undefined:
  - io_in is sampled directly (caller guarantees synchronous pad).
  - No extra flops.

Decomposition:
- Package std_io_shift_pkg holds:
  - state enum typedef std_io_shift_state_t.
  - localparam helper function for clamping lengths.
- One natural sub-module: std_io_bit_timer.
  - Phase counter, bit counter, wrap strobe, mid-bit strobe.
  - Restart input.

Test Plan (DATA_W=16, CLKS_PER_BIT=4, TURN_BITS=1, start at T):
- tx_len=8, tx_word=0x00A5, rx_len=0 -> io_data at ena pulses T+1,T+5,...,T+29 = 1,0,1,0,0,1,0,1; release pulse (drv=0) at T+33; done at T+37; rx_word=0.
- tx_len=4, tx_word=0x0009, rx_len=8, bench drives 0x3C MSB-first, one bit per bit time -> rx_word=0x003C; done at T+53.
- tx_len=0, rx_len=0 -> single release pulse at T+1; done at T+5; busy high T+1..T+4.
- tx_len=20 clamps to 16, tx_word=0xFFFF -> 16 drive-1 pulses; start pulsed at T+10 is ignored; done at T+69.
- clrn low at T+30 of the second scenario -> all outputs 0 asynchronously, no done; new start after release completes correctly.
- With STD_IO_BIDIR_SHIFTER_SYNC_EN and CLKS_PER_BIT=8 -> rerun the second scenario: rx_word=0x003C; CLKS_PER_BIT=4 fails elaboration.
